// File: rtl/bp_cce_hybrid_pending_wr_arb.sv
`default_nettype none
// bp_cce_hybrid_pending_wr_arb: merges buffered pending-bit increments and decrements
// onto one registered write port; decrements win unless an increment has starved.
module bp_cce_hybrid_pending_wr_arb #(
   parameter int paddr_width_p       = 40,
   parameter int addr_offset_p       = 6,
   parameter int lg_cce_way_groups_p = 4,
   parameter int lg_num_way_groups_p = 3,
   parameter int up_els_p            = 2,
   parameter int down_els_p          = 4,
   parameter int max_starve_p        = 3
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     up_v_i,
   output logic                     up_ready_and_o,
   input  logic [paddr_width_p-1:0] up_addr_i,
   input  logic                     up_bypass_i,
   input  logic                     up_clear_i,
   input  logic                     down_v_i,
   output logic                     down_ready_and_o,
   input  logic [paddr_width_p-1:0] down_addr_i,
   input  logic                     down_bypass_i,
   output logic                     w_v_o,
   output logic [paddr_width_p-1:0] w_addr_o,
   output logic                     w_addr_bypass_hash_o,
   output logic                     up_o,
   output logic                     down_o,
   output logic                     clear_o,
   output logic                     idle_o
);

   localparam int way_w_lp    = (lg_cce_way_groups_p > lg_num_way_groups_p)
                                ? lg_cce_way_groups_p : lg_num_way_groups_p;
   localparam int up_ptr_w_lp = (up_els_p > 1) ? $clog2(up_els_p) : 1;
   localparam int dn_ptr_w_lp = (down_els_p > 1) ? $clog2(down_els_p) : 1;
   localparam int up_cnt_w_lp = $clog2(up_els_p + 1);
   localparam int dn_cnt_w_lp = $clog2(down_els_p + 1);
   localparam int st_w_lp     = $clog2(max_starve_p + 1);

   localparam logic [up_ptr_w_lp-1:0] up_last_lp  = up_ptr_w_lp'(up_els_p - 1);
   localparam logic [dn_ptr_w_lp-1:0] dn_last_lp  = dn_ptr_w_lp'(down_els_p - 1);
   localparam logic [up_cnt_w_lp-1:0] up_full_lp  = up_cnt_w_lp'(up_els_p);
   localparam logic [dn_cnt_w_lp-1:0] dn_full_lp  = dn_cnt_w_lp'(down_els_p);
   localparam logic [st_w_lp-1:0]     st_max_lp   = st_w_lp'(max_starve_p);

   logic                     ready_en_q;
   logic [paddr_width_p-1:0] up_addr_mem [up_els_p];
   logic                     up_byp_mem  [up_els_p];
   logic                     up_clr_mem  [up_els_p];
   logic [paddr_width_p-1:0] dn_addr_mem [down_els_p];
   logic                     dn_byp_mem  [down_els_p];

   logic [up_ptr_w_lp-1:0] up_head_q, up_head_d, up_tail_q, up_tail_d;
   logic [dn_ptr_w_lp-1:0] dn_head_q, dn_head_d, dn_tail_q, dn_tail_d;
   logic [up_cnt_w_lp-1:0] up_cnt_q, up_cnt_d;
   logic [dn_cnt_w_lp-1:0] dn_cnt_q, dn_cnt_d;
   logic [st_w_lp-1:0]     starve_q, starve_d;

   logic                     w_v_q, w_v_d, w_byp_q, w_byp_d;
   logic                     up_q, up_d, down_q, down_d, clear_q, clear_d;
   logic [paddr_width_p-1:0] w_addr_q, w_addr_d;

   logic                 up_push, up_pop, dn_push, dn_pop;
   logic                 up_hv, dn_hv, coalesce, grant_up, grant_dn;
   logic [way_w_lp-1:0]  up_way, dn_way;
   logic [way_w_lp:0]    up_key, dn_key;

   // ready is held low until the first edge after reset release
   assign up_ready_and_o   = ready_en_q & (up_cnt_q != up_full_lp);
   assign down_ready_and_o = ready_en_q & (dn_cnt_q != dn_full_lp);
   assign up_push = up_v_i & up_ready_and_o;
   assign dn_push = down_v_i & down_ready_and_o;
   assign up_hv   = (up_cnt_q != '0);
   assign dn_hv   = (dn_cnt_q != '0);

   always_comb begin
      up_way = up_byp_mem[up_head_q]
               ? way_w_lp'(up_addr_mem[up_head_q][0+:lg_num_way_groups_p])
               : way_w_lp'(up_addr_mem[up_head_q][addr_offset_p+:lg_cce_way_groups_p]);
      dn_way = dn_byp_mem[dn_head_q]
               ? way_w_lp'(dn_addr_mem[dn_head_q][0+:lg_num_way_groups_p])
               : way_w_lp'(dn_addr_mem[dn_head_q][addr_offset_p+:lg_cce_way_groups_p]);
      up_key = {up_byp_mem[up_head_q], up_way};
      dn_key = {dn_byp_mem[dn_head_q], dn_way};
   end

   always_comb begin
      coalesce = up_hv & dn_hv & ~up_clr_mem[up_head_q] & (up_key == dn_key);
      grant_up = ~coalesce & up_hv & (~dn_hv | (starve_q == st_max_lp));
      grant_dn = ~coalesce & dn_hv & ~grant_up;
      up_pop   = grant_up | coalesce;
      dn_pop   = grant_dn | coalesce;

      starve_d = starve_q;
      if (~up_hv | grant_up)
         starve_d = '0;
      else if (grant_dn && (starve_q != st_max_lp))
         starve_d = starve_q + 1'b1;
   end

   always_comb begin
      up_head_d = up_head_q;
      up_tail_d = up_tail_q;
      dn_head_d = dn_head_q;
      dn_tail_d = dn_tail_q;
      if (up_pop)  up_head_d = (up_head_q == up_last_lp) ? '0 : up_head_q + 1'b1;
      if (up_push) up_tail_d = (up_tail_q == up_last_lp) ? '0 : up_tail_q + 1'b1;
      if (dn_pop)  dn_head_d = (dn_head_q == dn_last_lp) ? '0 : dn_head_q + 1'b1;
      if (dn_push) dn_tail_d = (dn_tail_q == dn_last_lp) ? '0 : dn_tail_q + 1'b1;
      up_cnt_d = up_cnt_q + up_cnt_w_lp'(up_push) - up_cnt_w_lp'(up_pop);
      dn_cnt_d = dn_cnt_q + dn_cnt_w_lp'(dn_push) - dn_cnt_w_lp'(dn_pop);
   end

   // idle cycles drive every write field back to zero
   always_comb begin
      w_v_d    = grant_up | grant_dn;
      up_d     = grant_up;
      down_d   = grant_dn;
      clear_d  = grant_up & up_clr_mem[up_head_q];
      w_addr_d = '0;
      w_byp_d  = 1'b0;
      if (grant_up) begin
         w_addr_d = up_addr_mem[up_head_q];
         w_byp_d  = up_byp_mem[up_head_q];
      end else if (grant_dn) begin
         w_addr_d = dn_addr_mem[dn_head_q];
         w_byp_d  = dn_byp_mem[dn_head_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (up_push) begin
         up_addr_mem[up_tail_q] <= up_addr_i;
         up_byp_mem[up_tail_q]  <= up_bypass_i;
         up_clr_mem[up_tail_q]  <= up_clear_i;
      end
      if (dn_push) begin
         dn_addr_mem[dn_tail_q] <= down_addr_i;
         dn_byp_mem[dn_tail_q]  <= down_bypass_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ready_en_q <= 1'b0;
         up_head_q  <= '0;
         up_tail_q  <= '0;
         up_cnt_q   <= '0;
         dn_head_q  <= '0;
         dn_tail_q  <= '0;
         dn_cnt_q   <= '0;
         starve_q   <= '0;
         w_v_q      <= 1'b0;
         w_addr_q   <= '0;
         w_byp_q    <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         clear_q    <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         up_head_q  <= up_head_d;
         up_tail_q  <= up_tail_d;
         up_cnt_q   <= up_cnt_d;
         dn_head_q  <= dn_head_d;
         dn_tail_q  <= dn_tail_d;
         dn_cnt_q   <= dn_cnt_d;
         starve_q   <= starve_d;
         w_v_q      <= w_v_d;
         w_addr_q   <= w_addr_d;
         w_byp_q    <= w_byp_d;
         up_q       <= up_d;
         down_q     <= down_d;
         clear_q    <= clear_d;
      end
   end

   assign w_v_o                = w_v_q;
   assign w_addr_o             = w_addr_q;
   assign w_addr_bypass_hash_o = w_byp_q;
   assign up_o                 = up_q;
   assign down_o               = down_q;
   assign clear_o              = clear_q;
   assign idle_o               = ~up_hv & ~dn_hv & ~w_v_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_hybrid_pending_wr_arb.sv
`default_nettype none
// tb_bp_cce_hybrid_pending_wr_arb: directed and random self-checking bench for
// the pending-bit write arbiter.
module tb_bp_cce_hybrid_pending_wr_arb;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        up_v_i, up_ready_and_o, up_bypass_i, up_clear_i;
   logic [15:0] up_addr_i;
   logic        down_v_i, down_ready_and_o, down_bypass_i;
   logic [15:0] down_addr_i;
   logic        w_v_o, w_addr_bypass_hash_o, up_o, down_o, clear_o, idle_o;
   logic [15:0] w_addr_o;

   int checks   = 0;
   int failures = 0;

   int net_exp [32];
   int net_obs [32];
   int acc_up, acc_dn, obs_up, obs_dn, overlap;

   bp_cce_hybrid_pending_wr_arb #(
      .paddr_width_p(16), .addr_offset_p(6), .lg_cce_way_groups_p(4),
      .lg_num_way_groups_p(3), .up_els_p(2), .down_els_p(4), .max_starve_p(3)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .up_v_i(up_v_i), .up_ready_and_o(up_ready_and_o), .up_addr_i(up_addr_i),
      .up_bypass_i(up_bypass_i), .up_clear_i(up_clear_i),
      .down_v_i(down_v_i), .down_ready_and_o(down_ready_and_o),
      .down_addr_i(down_addr_i), .down_bypass_i(down_bypass_i),
      .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_addr_bypass_hash_o(w_addr_bypass_hash_o),
      .up_o(up_o), .down_o(down_o), .clear_o(clear_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   function automatic int key_of(input logic [15:0] a, input logic b);
      return b ? (16 + int'(a[2:0])) : int'(a[9:6]);
   endfunction

   task automatic quiet();
      up_v_i = 1'b0; up_addr_i = '0; up_bypass_i = 1'b0; up_clear_i = 1'b0;
      down_v_i = 1'b0; down_addr_i = '0; down_bypass_i = 1'b0;
   endtask

   task automatic check_write(input string name, input logic dn, input logic clr,
                              input logic [15:0] addr);
      check({name, "_v"},     32'(w_v_o),   32'd1);
      check({name, "_down"},  32'(down_o),  32'(dn));
      check({name, "_up"},    32'(up_o),    32'(!dn));
      check({name, "_clear"}, 32'(clear_o), 32'(clr));
      check({name, "_addr"},  32'(w_addr_o), 32'(addr));
   endtask

   initial begin
      logic [15:0] st_addr [8];
      logic        st_dn   [8];
      quiet();
      reset_n_i = 1'b0;

      // reset state
      #1;
      check("rst_wv", 32'(w_v_o), 0);
      check("rst_idle", 32'(idle_o), 1);
      check("rst_up_rdy", 32'(up_ready_and_o), 0);
      check("rst_dn_rdy", 32'(down_ready_and_o), 0);
      check("rst_addr", 32'(w_addr_o), 0);
      @(negedge clk_i); @(negedge clk_i);
      reset_n_i = 1'b1;
      #1 check("rel_rdy_low", 32'(up_ready_and_o), 0);
      @(negedge clk_i);
      check("rel_up_rdy", 32'(up_ready_and_o), 1);
      check("rel_dn_rdy", 32'(down_ready_and_o), 1);

      // single increment, two-edge latency
      up_v_i = 1'b1; up_addr_i = 16'h1040;
      @(negedge clk_i);
      quiet();
      check("single_early", 32'(w_v_o), 0);
      @(negedge clk_i);
      check_write("single", 1'b0, 1'b0, 16'h1040);
      check("single_byp", 32'(w_addr_bypass_hash_o), 0);
      check("single_busy", 32'(idle_o), 0);
      @(negedge clk_i);
      check("single_after_wv", 32'(w_v_o), 0);
      check("single_after_idle", 32'(idle_o), 1);

      // asynchronous reset in the middle of down traffic
      for (int i = 0; i < 3; i++) begin
         down_v_i = 1'b1; down_addr_i = 16'h0011 + 16'(i);
         @(negedge clk_i);
      end
      @(posedge clk_i); #2;
      check("mid_wv_before", 32'(w_v_o), 1);
      quiet();
      reset_n_i = 1'b0;
      #1;
      check("mid_wv_async", 32'(w_v_o), 0);
      check("mid_dn_rdy", 32'(down_ready_and_o), 0);
      check("mid_idle", 32'(idle_o), 1);
      @(negedge clk_i); @(negedge clk_i);
      reset_n_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("mid_no_write", 32'(w_v_o), 0);
      end
      check("mid_idle_after", 32'(idle_o), 1);

      // ordering across pointer wrap-around, alternating bypass
      for (int i = 0; i < 10; i++) begin
         if (i >= 2) begin
            check_write("order", 1'b1, 1'b0, 16'(i - 2));
            check("order_byp", 32'(w_addr_bypass_hash_o), 32'((i - 2) % 2));
         end
         quiet();
         if (i < 8) begin
            check("order_rdy", 32'(down_ready_and_o), 1);
            down_v_i = 1'b1; down_addr_i = 16'(i); down_bypass_i = (i % 2) == 1;
         end
         @(negedge clk_i);
      end
      quiet();
      check("order_end", 32'(w_v_o), 0);

      // coalesce: same key (way group 2, hashed) presented together
      up_v_i = 1'b1; up_addr_i = 16'h0080;
      down_v_i = 1'b1; down_addr_i = 16'h0090;
      check("coal_up_rdy", 32'(up_ready_and_o), 1);
      check("coal_dn_rdy", 32'(down_ready_and_o), 1);
      @(negedge clk_i);
      quiet();
      check("coal_wv0", 32'(w_v_o), 0);
      @(negedge clk_i);
      check("coal_wv1", 32'(w_v_o), 0);
      check("coal_idle", 32'(idle_o), 1);

      // same key but clear: never coalesced, down first then clear
      up_v_i = 1'b1; up_addr_i = 16'h0080; up_clear_i = 1'b1;
      down_v_i = 1'b1; down_addr_i = 16'h0090;
      @(negedge clk_i);
      quiet();
      check("clr_wv0", 32'(w_v_o), 0);
      @(negedge clk_i);
      check_write("clr_first", 1'b1, 1'b0, 16'h0090);
      @(negedge clk_i);
      check_write("clr_second", 1'b0, 1'b1, 16'h0080);
      @(negedge clk_i);
      check("clr_end", 32'(w_v_o), 0);

      // starvation bound of 3: D,D,D,U,D,D,D,U with a full up FIFO
      st_dn   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      st_addr = '{16'h0300, 16'h0301, 16'h0302, 16'h0200,
                  16'h0303, 16'h0304, 16'h0305, 16'h0240};
      for (int k = 0; k <= 10; k++) begin
         if (k >= 2 && k <= 9) check_write("starve", st_dn[k-2], 1'b0, st_addr[k-2]);
         if (k == 10) check("starve_end", 32'(w_v_o), 0);
         if (k == 2) check("starve_up_full", 32'(up_ready_and_o), 0);
         quiet();
         if (k < 6) begin down_v_i = 1'b1; down_addr_i = 16'h0300 + 16'(k); end
         if (k < 2) begin up_v_i = 1'b1; up_addr_i = (k == 0) ? 16'h0200 : 16'h0240; end
         @(negedge clk_i);
      end
      quiet();

      // random stream against a per-key net-count scoreboard
      for (int i = 0; i < 32; i++) begin net_exp[i] = 0; net_obs[i] = 0; end
      acc_up = 0; acc_dn = 0; obs_up = 0; obs_dn = 0; overlap = 0;
      for (int c = 0; c < 330; c++) begin
         if (w_v_o) begin
            if (up_o & down_o) overlap++;
            if (up_o) begin net_obs[key_of(w_addr_o, w_addr_bypass_hash_o)]++; obs_up++; end
            if (down_o) begin net_obs[key_of(w_addr_o, w_addr_bypass_hash_o)]--; obs_dn++; end
         end
         quiet();
         if (c < 300) begin
            up_v_i = $urandom_range(0, 1) == 1;
            up_bypass_i = $urandom_range(0, 1) == 1;
            up_addr_i = 16'($urandom_range(0, 3) << 6) | 16'($urandom_range(0, 3));
            down_v_i = $urandom_range(0, 1) == 1;
            down_bypass_i = $urandom_range(0, 1) == 1;
            down_addr_i = 16'($urandom_range(0, 3) << 6) | 16'($urandom_range(0, 3));
            if (up_v_i & up_ready_and_o) begin
               net_exp[key_of(up_addr_i, up_bypass_i)]++; acc_up++;
            end
            if (down_v_i & down_ready_and_o) begin
               net_exp[key_of(down_addr_i, down_bypass_i)]--; acc_dn++;
            end
         end
         @(negedge clk_i);
      end
      quiet();
      for (int i = 0; i < 32; i++)
         check($sformatf("rand_net_key%0d", i), 32'(net_exp[i]), 32'(net_obs[i]));
      check("rand_overlap", 32'(overlap), 0);
      check("rand_lost", 32'(acc_up - obs_up), 32'(acc_dn - obs_dn));
      check("rand_idle", 32'(idle_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
